// File: rtl/fc_layer_pkg.sv
// Shared definitions for the fully-connected stage: memory select codes,
// fixed-point widths, address widths, FSM state encoding and the weight ROM
// address helper.
package fc_layer_pkg;

  // Fixed-point formats: data unsigned 4.16, weights/bias signed 4.16.
  localparam int unsigned DATA_W   = 20;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned WEIGHT_W = 20;
  localparam int unsigned ACC_W    = 53;
  localparam int unsigned OPD_W    = DATA_W + 1;        // zero-extended data operand
  localparam int unsigned PROD_W   = OPD_W + WEIGHT_W;  // 41-bit signed product
  localparam int unsigned RND_W    = DATA_W + 1;        // rounded result plus carry

  // Bus widths.
  localparam int unsigned CSEL_W  = 3;
  localparam int unsigned RADDR_W = 12;
  localparam int unsigned WADDR_W = 15;

  // Default layer geometry.
  localparam int unsigned N_IN_DEF    = 2048;
  localparam int unsigned NUM_OUT_DEF = 10;

  // Memory select codes on the shared csel bus. The image memory has its own
  // port, so its code coincides with "no access".
  localparam logic [CSEL_W-1:0] CSEL_NONE  = 3'b000;
  localparam logic [CSEL_W-1:0] CSEL_IMG   = 3'b000;
  localparam logic [CSEL_W-1:0] CSEL_L0_K0 = 3'b001;
  localparam logic [CSEL_W-1:0] CSEL_L0_K1 = 3'b010;
  localparam logic [CSEL_W-1:0] CSEL_L1_K0 = 3'b011;
  localparam logic [CSEL_W-1:0] CSEL_L1_K1 = 3'b100;
  localparam logic [CSEL_W-1:0] CSEL_L2    = 3'b101;
  localparam logic [CSEL_W-1:0] CSEL_RES   = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_FIN   = 3'd5
  } fc_state_e;

  // Weight ROM is row-major: row * n_in + col. Biases sit in row NUM_OUT.
  function automatic logic [WADDR_W-1:0] wrom_addr(input int unsigned row,
                                                   input int unsigned col,
                                                   input int unsigned n_in);
    return WADDR_W'(row * n_in + col);
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Multiply-accumulate pipeline for one output neuron plus result formation.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : synchronous clear of accumulator and pipeline valids
//   bias_ld       : weight_in carries the bias this cycle; load it into acc
//   in_vld        : data_in/weight_in carry one input term this cycle
//   data_in       : unsigned 4.16 activation
//   weight_in     : signed 4.16 weight or bias
//   result_c      : clamped, rounded, saturated 4.16 result of acc (combinational)
module fc_mac
  import fc_layer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                bias_ld,
  input  logic                in_vld,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [WEIGHT_W-1:0] weight_in,
  output logic [DATA_W-1:0]   result_c
);

  logic                       opv_q, opv_d;
  logic                       prodv_q, prodv_d;
  logic signed [OPD_W-1:0]    opd_q, opd_d;
  logic signed [WEIGHT_W-1:0] opw_q, opw_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [RND_W-1:0]           rnd_c;

  // Pipeline next-state: operand capture, product, accumulate.
  always_comb begin
    opv_d   = in_vld & ~clr;
    opd_d   = {1'b0, data_in};
    opw_d   = weight_in;
    prodv_d = opv_q & ~clr;
    prod_d  = opd_q * opw_q;
    acc_d   = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (bias_ld) begin
      // Bias is 4.16; the accumulator carries 32 fractional bits.
      acc_d = {{(ACC_W - WEIGHT_W - FRAC_W){weight_in[WEIGHT_W-1]}}, weight_in, FRAC_W'(0)};
    end else if (prodv_q) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opv_q   <= 1'b0;
      prodv_q <= 1'b0;
      opd_q   <= '0;
      opw_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
    end else begin
      opv_q   <= opv_d;
      prodv_q <= prodv_d;
      opd_q   <= opd_d;
      opw_q   <= opw_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

  // ReLU, then overflow saturation, then round-half-up with carry saturation.
  always_comb begin
    rnd_c = {1'b0, acc_q[FRAC_W+DATA_W-1:FRAC_W]} + RND_W'(acc_q[FRAC_W-1]);
    if (acc_q[ACC_W-1]) begin
      result_c = '0;
    end else if (|acc_q[ACC_W-1:FRAC_W+DATA_W]) begin
      result_c = '1;
    end else if (rnd_c[RND_W-1]) begin
      result_c = '1;
    end else begin
      result_c = rnd_c[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer controller. After start, for each neuron n it loads
// the bias, streams N_IN (activation, weight) pairs through fc_mac, flushes
// the pipeline and writes one 4.16 result to the result memory.
//   clk, reset          : clock, asynchronous active-high reset
//   start / busy / done : request, run indicator, end-of-run pulse
//   crd, caddr_rd, cdata_rd : layer-2 memory read port
//   csel                : memory select (SRC_SEL on reads, RES_SEL on writes)
//   cwr, caddr_wr, cdata_wr : result memory write port
//   wrd, waddr, wdata   : weight ROM read port
module fc_layer
  import fc_layer_pkg::*;
#(
  parameter int unsigned       N_IN    = N_IN_DEF,
  parameter int unsigned       NUM_OUT = NUM_OUT_DEF,
  parameter logic [CSEL_W-1:0] SRC_SEL = CSEL_L2,
  parameter logic [CSEL_W-1:0] RES_SEL = CSEL_RES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                crd,
  output logic [RADDR_W-1:0]  caddr_rd,
  input  logic [DATA_W-1:0]   cdata_rd,
  output logic [CSEL_W-1:0]   csel,
  output logic                cwr,
  output logic [RADDR_W-1:0]  caddr_wr,
  output logic [DATA_W-1:0]   cdata_wr,
  output logic                wrd,
  output logic [WADDR_W-1:0]  waddr,
  input  logic [WEIGHT_W-1:0] wdata
);

  localparam int unsigned N_W       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned CNT_W     = RADDR_W;
  localparam int unsigned DRAIN_LEN = 3;

  fc_state_e           state_q, state_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [CNT_W-1:0]    i_nxt;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                crd_q, crd_d;
  logic [RADDR_W-1:0]  caddr_rd_q, caddr_rd_d;
  logic [CSEL_W-1:0]   csel_q, csel_d;
  logic                cwr_q, cwr_d;
  logic [RADDR_W-1:0]  caddr_wr_q, caddr_wr_d;
  logic [DATA_W-1:0]   cdata_wr_q, cdata_wr_d;
  logic                wrd_q, wrd_d;
  logic [WADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]   result_c;

  assign i_nxt = i_q + CNT_W'(1);

  // Next state and next registered outputs. Outputs are computed for the
  // state being entered so that strobes line up with that state's cycles.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crd_d      = 1'b0;
    caddr_rd_d = '0;
    csel_d     = CSEL_NONE;
    cwr_d      = 1'b0;
    caddr_wr_d = '0;
    cdata_wr_d = '0;
    wrd_d      = 1'b0;
    waddr_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BIAS;
          n_d     = '0;
          busy_d  = 1'b1;
          wrd_d   = 1'b1;
          waddr_d = wrom_addr(NUM_OUT, 0, N_IN);
        end
      end
      ST_BIAS: begin
        state_d    = ST_RUN;
        i_d        = '0;
        crd_d      = 1'b1;
        csel_d     = SRC_SEL;
        caddr_rd_d = '0;
        wrd_d      = 1'b1;
        waddr_d    = wrom_addr(32'(n_q), 0, N_IN);
      end
      ST_RUN: begin
        if (i_q == CNT_W'(N_IN - 1)) begin
          state_d = ST_DRAIN;
          i_d     = '0;
        end else begin
          i_d        = i_nxt;
          crd_d      = 1'b1;
          csel_d     = SRC_SEL;
          caddr_rd_d = RADDR_W'(i_nxt);
          wrd_d      = 1'b1;
          waddr_d    = wrom_addr(32'(n_q), 32'(i_nxt), N_IN);
        end
      end
      ST_DRAIN: begin
        // The last product reaches the accumulator before the final drain cycle ends.
        if (i_q == CNT_W'(DRAIN_LEN - 1)) begin
          state_d    = ST_WRITE;
          cwr_d      = 1'b1;
          csel_d     = RES_SEL;
          caddr_wr_d = RADDR_W'(n_q);
          cdata_wr_d = result_c;
        end else begin
          i_d = i_nxt;
        end
      end
      ST_WRITE: begin
        if (n_q == N_W'(NUM_OUT - 1)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_BIAS;
          n_d     = n_q + N_W'(1);
          wrd_d   = 1'b1;
          waddr_d = wrom_addr(NUM_OUT, 32'(n_q) + 1, N_IN);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      caddr_rd_q <= '0;
      csel_q     <= CSEL_NONE;
      cwr_q      <= 1'b0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      wrd_q      <= 1'b0;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      caddr_rd_q <= caddr_rd_d;
      csel_q     <= csel_d;
      cwr_q      <= cwr_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      wrd_q      <= wrd_d;
      waddr_q    <= waddr_d;
    end
  end

  // Data returned during the BIAS cycle is the bias; during read cycles it is a term.
  fc_mac u_mac (
    .clk       (clk),
    .rst       (reset),
    .clr       (state_q == ST_IDLE),
    .bias_ld   (state_q == ST_BIAS),
    .in_vld    (crd_q),
    .data_in   (cdata_rd),
    .weight_in (wdata),
    .result_c  (result_c)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign csel     = csel_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign wrd      = wrd_q;
  assign waddr    = waddr_q;

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: two full runs with hand-computed results, a
// run aborted by reset, protocol monitoring of csel/strobes/address order.
module tb_fc_layer;

  localparam int N     = 2048;
  localparam int NO    = 10;
  localparam int WN    = NO * N + NO;
  localparam int BIAS0 = NO * N;
  localparam int T_RUN = NO * (N + 5) + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, crd, cwr, wrd;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd, cdata_wr, wdata;
  logic [2:0]  csel;
  logic [14:0] waddr;

  logic [19:0] l2_mem [0:N-1];
  logic [19:0] w_mem  [0:WN-1];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fc_layer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .wrd      (wrd),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  // Memories drive data during the strobe cycle; the DUT samples it on the next edge.
  assign cdata_rd = crd ? l2_mem[caddr_rd[10:0]] : 20'h0;
  assign wdata    = (wrd && (int'(waddr) < WN)) ? w_mem[waddr] : 20'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor, sampled on the falling edge.
  int          ovl_cnt = 0;
  int          csel_err = 0;
  int          done_cnt = 0;
  logic [2:0]  csel_exp;
  logic [14:0] wa_q [$];
  logic [11:0] ca_q [$];
  bit          cr_q [$];
  logic [11:0] wr_addr_q [$];
  logic [19:0] wr_data_q [$];

  always @(negedge clk) begin
    csel_exp = crd ? 3'b101 : (cwr ? 3'b110 : 3'b000);
    if (crd && cwr) ovl_cnt++;
    if (crd && !wrd) ovl_cnt++;
    if (csel !== csel_exp) csel_err++;
    if (done) done_cnt++;
    if (wrd) begin
      wa_q.push_back(waddr);
      ca_q.push_back(caddr_rd);
      cr_q.push_back(crd);
    end
    if (cwr) begin
      wr_addr_q.push_back(caddr_wr);
      wr_data_q.push_back(cdata_wr);
    end
  end

  function automatic int widx(input int n, input int i);
    return n * N + i;
  endfunction

  task automatic do_run(input int abort_at, output int cycles, output bit saw_done);
    int cyc;
    cyc = 0;
    saw_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    while (cyc < T_RUN + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
      // Extra start pulses while busy must be ignored.
      start = (cyc == 700 || cyc == 2052 || cyc == 15000);
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (cyc == abort_at) break;
    end
    cycles = cyc;
  endtask

  task automatic finish_run(input string tag, input int cycles, input bit saw_done,
                            input int wr_base, input int done_base,
                            input logic [19:0] exp [NO]);
    chk({tag, "_done_seen"}, 64'(saw_done), 64'd1);
    chk({tag, "_latency"}, 64'(cycles), 64'(T_RUN));
    // start in the done cycle is ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_idle_after_done"}, 64'(busy), 64'd0);
    chk({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    chk({tag, "_wr_count"}, 64'(wr_addr_q.size() - wr_base), 64'(NO));
    for (int k = 0; k < NO; k++) begin
      chk($sformatf("%s_wr_addr%0d", tag, k), 64'(wr_addr_q[wr_base + k]), 64'(k));
      chk($sformatf("%s_result%0d", tag, k), 64'(wr_data_q[wr_base + k]), 64'(exp[k]));
    end
  endtask

  logic [19:0] exp1 [NO];
  logic [19:0] exp2 [NO];
  int          cycles, wr_base, done_base, rd_base, seq_err;
  bit          saw_done;

  initial begin
    exp1 = '{20'h10000, 20'h00000, 20'h00001, 20'h00000, 20'h00000,
             20'h7FFFF, 20'h00008, 20'h0FFF8, 20'h00100, 20'hFFFFF};
    exp2 = '{20'h08000, 20'hFFFFF, 20'h00000, 20'h00001, 20'h04000,
             20'h00500, 20'h00600, 20'h00700, 20'h00800, 20'h00900};

    // Run 1 data: sparse inputs exercising bias, ReLU, rounding and carry saturation.
    for (int i = 0; i < N; i++) l2_mem[i] = 20'h0;
    for (int i = 0; i < WN; i++) w_mem[i] = 20'h0;
    l2_mem[0] = 20'h00001;
    l2_mem[1] = 20'hFFFFF;
    w_mem[BIAS0 + 0]  = 20'h10000;
    w_mem[BIAS0 + 1]  = 20'hF0000;
    w_mem[widx(2, 0)] = 20'h08000;
    w_mem[widx(3, 0)] = 20'h04000;
    w_mem[widx(4, 0)] = 20'hF8000;
    w_mem[BIAS0 + 5]  = 20'h7FFFF;
    w_mem[widx(6, 0)] = 20'h7FFFF;
    w_mem[BIAS0 + 7]  = 20'h10000;
    w_mem[widx(7, 0)] = 20'h80000;
    w_mem[widx(8, 1)] = 20'h00010;
    w_mem[widx(9, 0)] = 20'h08000;
    w_mem[widx(9, 1)] = 20'h10000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({crd, cwr, wrd, done}), 64'd0);
    chk("rst_csel", 64'(csel), 64'd0);
    chk("rst_addr_data", 64'({caddr_rd, caddr_wr, waddr, cdata_wr}), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Run 1
    wr_base = wr_addr_q.size();
    done_base = done_cnt;
    rd_base = wa_q.size();
    do_run(0, cycles, saw_done);
    finish_run("run1", cycles, saw_done, wr_base, done_base, exp1);
    chk("run1_wrd_count", 64'(wa_q.size() - rd_base), 64'(NO * (N + 1)));
    // Address sequence for neuron 1: bias fetch without read, then 2048 terms.
    seq_err = 0;
    if (wa_q.size() >= rd_base + 2 * (N + 1)) begin
      if (wa_q[rd_base + N + 1] !== 15'(BIAS0 + 1) || cr_q[rd_base + N + 1] !== 1'b0) seq_err++;
      for (int i = 0; i < N; i++) begin
        if (wa_q[rd_base + N + 2 + i] !== 15'(N + i)) seq_err++;
        if (ca_q[rd_base + N + 2 + i] !== 12'(i)) seq_err++;
        if (cr_q[rd_base + N + 2 + i] !== 1'b1) seq_err++;
      end
    end else begin
      seq_err = -1;
    end
    chk("n1_addr_seq_errors", 64'(seq_err), 64'd0);
    chk("n1_bias_addr", 64'(wa_q[rd_base + N + 1]), 64'd20481);

    // Aborted run: reset at cycle 1000.
    wr_base = wr_addr_q.size();
    done_base = done_cnt;
    do_run(1000, cycles, saw_done);
    chk("abort_reached", 64'(cycles), 64'd1000);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_strobes", 64'({crd, cwr, wrd, done}), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_csel", 64'(csel), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_write", 64'(wr_addr_q.size() - wr_base), 64'd0);
    chk("abort_no_done", 64'(done_cnt - done_base), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    // Run 2 data: dense uniform inputs, then restart.
    for (int i = 0; i < N; i++) l2_mem[i] = 20'h10000;
    for (int i = 0; i < WN; i++) w_mem[i] = 20'h0;
    for (int i = 0; i < N; i++) begin
      w_mem[widx(0, i)] = 20'h00010;
      w_mem[widx(1, i)] = 20'h7FFFF;
      w_mem[widx(2, i)] = 20'h80000;
      if (i < N / 2) w_mem[widx(4, i)] = 20'h00010;
    end
    w_mem[BIAS0 + 3] = 20'h00001;
    for (int n = 5; n < NO; n++) w_mem[BIAS0 + n] = 20'(n << 8);

    wr_base = wr_addr_q.size();
    done_base = done_cnt;
    do_run(0, cycles, saw_done);
    finish_run("run2", cycles, saw_done, wr_base, done_base, exp2);

    chk("crd_cwr_overlap", 64'(ovl_cnt), 64'd0);
    chk("csel_errors", 64'(csel_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
